// File: rtl/f32_mult_arbiter_if.sv
// -----------------------------------------------------------------------------
// f32_mult_arbiter_if
//   Requester-side bus of the shared f32 multiplier arbiter.
//   master : requester side (drives operands, receives results)
//   slave  : arbiter side
// Signals
//   req_valid [N_REQ]     requester i has an operand pair pending
//   req_a/req_b [32*N]    operands, requester i at [32*i +: 32]
//   req_ready [N_REQ]     one-hot accept
//   rsp_valid [N_REQ]     one-hot 1-cycle result strobe
//   rsp_p [32]            product (IEEE-754 single)
//   rsp_err               timeout abort flag, valid with rsp_valid
// -----------------------------------------------------------------------------
interface f32_mult_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req_valid;
    logic [32*N_REQ-1:0] req_a;
    logic [32*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    rsp_valid;
    logic [31:0]         rsp_p;
    logic                rsp_err;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_p, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_p, rsp_err
    );
endinterface

// File: rtl/f32_mult_arbiter.sv
// -----------------------------------------------------------------------------
// f32_mult_arbiter
//   Shares one f32_mult between N_REQ requesters. Round-robin grant with a
//   single operation in flight: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   Operands are latched at accept and held on mult_a/mult_b for the whole op.
// Ports
//   clk, rst_n   clock (rising edge), synchronous active-low reset
//   bus          requester bus (f32_mult_arbiter_if.slave)
//   mult_start   1-cycle start pulse to f32_mult (ISSUE state)
//   mult_a/b     latched operands to f32_mult
//   mult_done    done pulse from f32_mult, honoured only in WAIT
//   mult_p       product from f32_mult, valid with mult_done
// Configuration
//   F32_MARB_TIMEOUT_EN  when defined, WAIT aborts after TIMEOUT cycles
//                        without mult_done, returning 7FC00000 with rsp_err=1.
// -----------------------------------------------------------------------------
module f32_mult_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    f32_mult_arbiter_if.slave   bus,
    output logic                mult_start,
    output logic [31:0]         mult_a,
    output logic [31:0]         mult_b,
    input  logic                mult_done,
    input  logic [31:0]         mult_p
);
    localparam int IW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("f32_mult_arbiter: N_REQ must be 2..8 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] gnt;
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    logic          any_req;
    logic          accept;
    logic          capture;
    logic [31:0]   capture_val;
    logic [31:0]   op_a, op_b;
    logic [31:0]   rsp_p_q;

    assign any_req = |bus.req_valid;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping.
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

`ifdef F32_MARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt;
    logic          capture_err;
    logic          err_q;
`endif

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        capture     = 1'b0;
        capture_val = mult_p;
`ifdef F32_MARB_TIMEOUT_EN
        capture_err = 1'b0;
`endif
        case (state)
            IDLE: begin
                // Granted requester is valid by construction, so any pending
                // request completes the handshake this cycle.
                if (any_req) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (mult_done) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
`ifdef F32_MARB_TIMEOUT_EN
                else if (to_cnt == TW'(TIMEOUT - 1)) begin
                    capture     = 1'b1;
                    capture_val = 32'h7FC0_0000;
                    capture_err = 1'b1;
                    state_nxt   = RESP;
                end
`endif
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            gnt     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            rsp_p_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                gnt  <= pick;
                op_a <= bus.req_a[32*int'(pick) +: 32];
                op_b <= bus.req_b[32*int'(pick) +: 32];
            end
            if (capture) rsp_p_q <= capture_val;
            // Pointer moves past the requester just served, so a waiting
            // competitor is found before it on the next search.
            if (state == RESP) rr_ptr <= (gnt == IW'(N_REQ - 1)) ? '0 : gnt + IW'(1);
        end
    end

`ifdef F32_MARB_TIMEOUT_EN
    // Counter is held at zero outside WAIT, which clears it on WAIT entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            to_cnt <= (state == WAIT) ? to_cnt + TW'(1) : '0;
            if (capture) err_q <= capture_err;
        end
    end
    assign bus.rsp_err = (state == RESP) && err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready = (state == IDLE && any_req) ? (N_REQ'(1) << pick) : '0;
    assign bus.rsp_valid = (state == RESP) ? (N_REQ'(1) << gnt) : '0;
    assign bus.rsp_p     = rsp_p_q;
    assign mult_start    = (state == ISSUE);
    assign mult_a        = op_a;
    assign mult_b        = op_b;
endmodule

// File: tb/tb_f32_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_f32_mult_arbiter
//   Drives f32_mult_arbiter with a programmable-latency multiplier model.
//   Operands are small integers encoded as floats so products are exact.
//   A transaction-level reference (pending set, pointer, op in flight)
//   predicts grants, start pulse, held operands and responses each cycle.
// -----------------------------------------------------------------------------
module tb_f32_mult_arbiter;
    localparam int N  = 4;
    localparam int TO = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    f32_mult_arbiter_if #(.N_REQ(N)) ifc ();

    logic        mult_start;
    logic [31:0] mult_a, mult_b, mult_p;
    logic        mult_done;

    f32_mult_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (ifc.slave),
        .mult_start (mult_start),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_done  (mult_done),
        .mult_p     (mult_p)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] int_to_f32(input int unsigned n);
        int e;
        logic [31:0] m;
        e = 0;
        if (n == 0) return 32'h0;
        for (int k = 0; k < 32; k++) if (n[k]) e = k;
        m = (n << (23 - e)) & 32'h007F_FFFF;
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    function automatic int unsigned f32_to_int(input logic [31:0] f);
        int e;
        logic [31:0] m;
        if (f == 32'h0) return 0;
        e = int'(f[30:23]) - 127;
        m = {9'b1, f[22:0]};
        return m >> (23 - e);
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
        return 0;
    endfunction

    // ---------------- multiplier model ----------------
    int          mult_lat = 3;
    bit          never_done = 0;
    logic        stray_done = 1'b0;
    logic        model_done = 1'b0;
    logic [31:0] model_p = 32'h0;
    logic        model_busy = 1'b0;
    int          model_cnt = 0;

    assign mult_done = model_done | stray_done;
    assign mult_p    = model_p;

    // Product is formed from the operands present at done time, so any
    // operand change during the op shows up in the result.
    always @(posedge clk) begin
        model_done <= 1'b0;
        if (!rst_n) begin
            model_busy <= 1'b0;
            model_cnt  <= 0;
        end else if (mult_start) begin
            model_busy <= 1'b1;
            model_cnt  <= mult_lat;
        end else if (model_busy && !never_done) begin
            if (model_cnt <= 1) begin
                model_done <= 1'b1;
                model_p    <= int_to_f32(f32_to_int(mult_a) * f32_to_int(mult_b));
                model_busy <= 1'b0;
            end else begin
                model_cnt <= model_cnt - 1;
            end
        end
    end

    // ---------------- reference state ----------------
    int          cyc = 0;
    bit          m_busy = 0, m_started = 0, m_done_seen = 0;
    int          m_g = 0, m_acc_cyc = 0, m_start_cyc = 0, m_ptr = 0;
    int unsigned m_ia = 0, m_ib = 0;
    logic [31:0] m_last_p = 32'h0;
    int          resp_count = 0, start_count = 0, err_count = 0;
    int          grant_log[$];
    bit          accepted[N];
    int unsigned op_ia[N], op_ib[N];

    task automatic drive_req(input int i, input int unsigned a, input int unsigned b, input logic v);
        op_ia[i] = a;
        op_ib[i] = b;
        ifc.req_a[32*i +: 32] = int_to_f32(a);
        ifc.req_b[32*i +: 32] = int_to_f32(b);
        ifc.req_valid[i] = v;
    endtask

    // Called at the falling edge: compare, then advance the reference.
    task automatic monitor();
        logic [N-1:0] exp_ready, exp_rv;
        logic [31:0]  exp_p;
        bit           exp_start, resp_now, to_now;
        cyc++;
        exp_ready = '0;
        if (!m_busy && |ifc.req_valid) exp_ready = N'(1) << pick(ifc.req_valid, m_ptr);
        check("req_ready", 32'(ifc.req_ready), 32'(exp_ready));
        exp_start = m_busy && !m_started && (cyc == m_acc_cyc + 1);
        check("mult_start", 32'(mult_start), 32'(exp_start));
        if (mult_start) start_count++;
        if (m_busy && (m_started || exp_start)) begin
            check("mult_a_hold", mult_a, int_to_f32(m_ia));
            check("mult_b_hold", mult_b, int_to_f32(m_ib));
        end
        resp_now = m_busy && m_done_seen;
        to_now   = 0;
`ifdef F32_MARB_TIMEOUT_EN
        to_now = m_busy && m_started && !m_done_seen && (cyc == m_start_cyc + 1 + TO);
`endif
        exp_rv = (resp_now || to_now) ? (N'(1) << m_g) : '0;
        if (resp_now)     exp_p = int_to_f32(m_ia * m_ib);
        else if (to_now)  exp_p = 32'h7FC0_0000;
        else              exp_p = m_last_p;
        check("rsp_valid", 32'(ifc.rsp_valid), 32'(exp_rv));
        check("rsp_p", ifc.rsp_p, exp_p);
        check("rsp_err", 32'(ifc.rsp_err), 32'(to_now));
        if (ifc.rsp_err) err_count++;

        if (resp_now || to_now) begin
            m_busy   = 0;
            m_ptr    = (m_g + 1) % N;
            m_last_p = exp_p;
            resp_count++;
        end else if (m_busy) begin
            if (exp_start) begin
                m_started   = 1;
                m_start_cyc = cyc;
            end else if (m_started && mult_done) begin
                m_done_seen = 1;
            end
        end else if (rst_n && |ifc.req_valid) begin
            m_g         = pick(ifc.req_valid, m_ptr);
            m_ia        = op_ia[m_g];
            m_ib        = op_ib[m_g];
            m_busy      = 1;
            m_started   = 0;
            m_done_seen = 0;
            m_acc_cyc   = cyc;
            accepted[m_g] = 1;
            grant_log.push_back(m_g);
        end
    endtask

    // One clock: check at the falling edge, return 1 time unit after the
    // rising edge; a reset taken at that edge clears the reference.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_busy = 0; m_started = 0; m_done_seen = 0;
            m_ptr = 0; m_last_p = 32'h0;
        end
    endtask

    task automatic run_until_resp(input string tag, input int target, input int limit);
        for (int k = 0; k < limit && resp_count < target; k++) step();
        check(tag, 32'(resp_count >= target), 32'd1);
    endtask

    task automatic run_until_accept(input string tag, input int i, input int limit);
        for (int k = 0; k < limit && !accepted[i]; k++) step();
        check(tag, 32'(accepted[i]), 32'd1);
    endtask

    task automatic clear_accepted();
        for (int i = 0; i < N; i++) accepted[i] = 0;
    endtask

    initial begin
        int base, s0, gl;
        ifc.req_valid = '0;
        ifc.req_a     = '0;
        ifc.req_b     = '0;
        for (int i = 0; i < N; i++) begin op_ia[i] = 1; op_ib[i] = 1; accepted[i] = 0; end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(ifc.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        check("rst_rsp_p", ifc.rsp_p, 32'd0);
        check("rst_rsp_err", 32'(ifc.rsp_err), 32'd0);
        check("rst_mult_start", 32'(mult_start), 32'd0);
        check("rst_mult_a", mult_a, 32'd0);
        check("rst_mult_b", mult_b, 32'd0);
        rst_n = 1'b1;
        step();

        // 1. Single op: 1.0 * 2.0 on requester 0
        s0 = start_count;
        drive_req(0, 1, 2, 1'b1);
        run_until_accept("t1_accept", 0, 10);
        ifc.req_valid[0] = 1'b0;
        clear_accepted();
        run_until_resp("t1_resp", resp_count + 1, 50);
        check("t1_product", m_last_p, 32'h4000_0000);
        check("t1_one_start", 32'(start_count - s0), 32'd1);

        // 2. All requesters hold valid from reset: strict rotation
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        base = grant_log.size();
        drive_req(0, 3, 4, 1'b1);
        drive_req(1, 5, 6, 1'b1);
        drive_req(2, 7, 8, 1'b1);
        drive_req(3, 9, 10, 1'b1);
        run_until_resp("t2_resp", resp_count + 5, 200);
        ifc.req_valid = '0;
        clear_accepted();
        run_until_resp("t2_drain", resp_count + (m_busy ? 1 : 0), 50);
        for (int k = 0; k < 5; k++) begin
            gl = (base + k < grant_log.size()) ? grant_log[base + k] : -1;
            check($sformatf("t2_grant%0d", k), 32'(gl), 32'(k % N));
        end

        // 3. Operand hold: requester 2 changes operands right after handshake
        mult_lat = 6;
        drive_req(2, 100, 37, 1'b1);
        run_until_accept("t3_accept", 2, 10);
        drive_req(2, 2047, 3, 1'b0);
        clear_accepted();
        run_until_resp("t3_resp", resp_count + 1, 50);
        check("t3_product", m_last_p, int_to_f32(3700));

        // 4. Reset mid-WAIT, then next op goes to requester 0
        mult_lat = 20;
        drive_req(1, 11, 13, 1'b1);
        run_until_accept("t4_accept", 1, 10);
        ifc.req_valid[1] = 1'b0;
        clear_accepted();
        repeat (4) step();
        s0 = resp_count;
        rst_n = 1'b0;
        step();
        check("t4_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        check("t4_mult_start", 32'(mult_start), 32'd0);
        check("t4_rsp_p", ifc.rsp_p, 32'd0);
        check("t4_rsp_err", 32'(ifc.rsp_err), 32'd0);
        check("t4_mult_a", mult_a, 32'd0);
        check("t4_mult_b", mult_b, 32'd0);
        rst_n = 1'b1;
        repeat (25) step();
        check("t4_no_resp", 32'(resp_count - s0), 32'd0);
        mult_lat = 2;
        drive_req(0, 6, 7, 1'b1);
        drive_req(3, 8, 9, 1'b1);
        run_until_accept("t4_accept0", 0, 10);
        ifc.req_valid = '0;
        clear_accepted();
        run_until_resp("t4_resp", resp_count + 1, 50);
        check("t4_regrant", 32'(grant_log[grant_log.size() - 1]), 32'd0);

        // 5. Stray mult_done in IDLE
        s0 = resp_count;
        stray_done = 1'b1;
        step();
        stray_done = 1'b0;
        drive_req(3, 15, 15, 1'b1);
        step();
        ifc.req_valid[3] = 1'b0;
        clear_accepted();
        run_until_resp("t5_resp", s0 + 1, 50);
        check("t5_product", m_last_p, int_to_f32(225));

`ifdef F32_MARB_TIMEOUT_EN
        // 6. Timeout abort, then normal service
        never_done = 1;
        s0 = err_count;
        drive_req(1, 2, 2, 1'b1);
        run_until_accept("t6_accept", 1, 10);
        ifc.req_valid[1] = 1'b0;
        clear_accepted();
        run_until_resp("t6_abort", resp_count + 1, 100);
        check("t6_err_seen", 32'(err_count - s0), 32'd1);
        never_done = 0;
        drive_req(2, 4, 5, 1'b1);
        run_until_accept("t6_accept2", 2, 10);
        ifc.req_valid[2] = 1'b0;
        clear_accepted();
        run_until_resp("t6_resp", resp_count + 1, 50);
        check("t6_product", m_last_p, int_to_f32(20));
`endif

        // Randomized traffic
        s0 = resp_count;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (accepted[i]) begin
                    accepted[i] = 0;
                    if ($urandom_range(1) == 0) ifc.req_valid[i] = 1'b0;
                    else drive_req(i, $urandom_range(1, 4095), $urandom_range(1, 4095), 1'b1);
                end else if (!ifc.req_valid[i]) begin
                    if ($urandom_range(9) < 3) drive_req(i, $urandom_range(1, 4095), $urandom_range(1, 4095), 1'b1);
                end else if ($urandom_range(19) == 0) begin
                    ifc.req_valid[i] = 1'b0;
                end
            end
            mult_lat   = $urandom_range(1, 8);
            stray_done = (!m_busy && $urandom_range(29) == 0);
            step();
        end
        stray_done    = 1'b0;
        ifc.req_valid = '0;
        clear_accepted();
        run_until_resp("rand_drain", resp_count + (m_busy ? 1 : 0), 50);
        check("rand_progress", 32'(resp_count - s0 > 20), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
